lpc_decoder_multi: RTL and testbench
====================================

// Module: lpc_decoder_multi
// PURPOSE
//  Passive LPC bus decoder: samples LAD/LFRAME# and reports each completed cycle as one record
//  (cyctype/dir, address, data, byte count, status). Successor of the single-transfer lpc decoder.
//  Adds I/O and memory cycles of 1/2/4 bytes, firmware-hub (FWH) cycles, wait-sync with
//  timeout, sync-error and abort reporting. Sits between LPC pins and capture FIFO/UART logic.
// PARAMETERS
//  MAX_BYTES     4   largest accepted transfer, bytes (1, 2 or 4); larger sizes -> status 2'b11
//  ENABLE_FW     1   1 = decode FWH starts 4'b1101/4'b1110; 0 = treat them as no-start
//  SYNC_TIMEOUT  64  max consecutive wait-sync nibbles (0101/0110) before status 2'b10
// PORTS
//  lpc_clock         in   1   LPC clock, all logic on rising edge
//  lpc_reset         in   1   LRESET#, asynchronous, active-low
//  lpc_ad            in   4   LAD[3:0]
//  lpc_frame         in   1   LFRAME#, active-low
//  out_cyctype_dir   out  4   cycle type/dir nibble; FWH reported as {2'b11,dir,1'b0}
//  out_addr          out  32  address; I/O zero-extended 16b; FWH = {idsel,addr28}
//  out_data          out  32  data, little-endian, right-justified, unused bytes 0
//  out_data_size     out  3   bytes transferred (1, 2, 4)
//  out_status        out  2   00 ok, 01 sync error (1010), 10 timeout, 11 size unsupported
//  out_clock_enable  out  1   one-cycle record strobe; record valid while high, held until next
//  out_abort         out  1   one-cycle pulse: cycle aborted by LFRAME# low with LAD=1111
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0; reset mid-cycle discards the cycle, no strobe.
//  START: LFRAME#=0 & LAD=0000 -> CTDIR; LAD=1101/1110 & ENABLE_FW -> FW_IDSEL; other -> IDLE.
//  LFRAME# low for several clocks: last sampled nibble while low is the START nibble.
//  CTDIR: bits[3:2] 00 I/O, 01 mem; bit1 dir (0 read, 1 write); 1x (DMA) -> IDLE silently.
//  SIZE: 1 nibble, 0->1B, 1->2B, 3->4B; 2 or >MAX_BYTES: continue decode, status 11, data 0.
//  ADDR: 4 nibbles (I/O) or 8 (mem), MS nibble first.
//  FWH: IDSEL 1 nibble, ADDR 7 nibbles, MSIZE 1 nibble (0000/0001/0010 -> 1/2/4B, else 11).
//  Read order: ADDR -> TAR1(2) -> SYNC -> DATA -> TAR2(2).
//  Write order: ADDR -> DATA -> TAR1(2) -> SYNC -> TAR2(2).
//  DATA: 2 nibbles per byte, low nibble first, byte 0 first.
//  SYNC: 0000 ready; 0101/0110 wait (count++); 1010 error -> status 01, continue frame;
//   any other nibble -> status 01, to TAR2. Count reaching SYNC_TIMEOUT -> status 10, IDLE.
//  Strobe: out_clock_enable=1 on the clock after the 2nd TAR2 nibble; outputs update that edge.
//  Timeout also strobes (status 10, data 0) on the clock after detection.
//  Abort: LFRAME#=0 & LAD=1111 in any non-IDLE state -> out_abort pulse next clock, IDLE, no strobe.
//  LFRAME#=0 & LAD=0000 in any non-IDLE state: drop current cycle, restart (no strobe, no abort).
//  Back-to-back: START may be sampled on the cycle immediately after the 2nd TAR2 nibble.
//  Sniffer only: no outputs drive LPC pins.
// STRUCTURE
//  Shared header lpc_defs.vh: FSM state codes, cyctype codes, START/SYNC nibble constants,
//   status codes; included by decoder and lpc_lib.v tasks.
//  Sub-module lpc_nibble_shift: load/shift nibble accumulator with nibble counter, two instances.
//   MSB-first instance for addr; LSB-first instance for data.
//  Top: FSM, sync wait counter ($clog2(SYNC_TIMEOUT+1) bits), output registers.
// TESTING
//  Mem read 2B: addr 0xaffe7fe5, data 0xdf6c, sync 0000 -> 1 strobe, ctdir 4, size 2, status 00.
//  I/O write 1B: addr 0x0080, data 0x5a -> ctdir 2, addr 0x00000080, data 0x5a, size 1.
//  Mem read 4B, 3 x 0110 then 0000 -> data 0x12345678, size 4, status 00.
//  Timeout: SYNC_TIMEOUT=8, 9 x 0101 -> one strobe, status 10, data 0.
//  Abort: LFRAME# low with LAD 1111 during ADDR -> out_abort pulse, no strobe.
//  Abort recovery: next 1B I/O read of 0x3f8 decodes correctly.
//  FWH read: START 1101, idsel 0, addr 0xfffffc0, msize 0010, data 0xcafebabe
//   -> ctdir 4'b1100, addr 0x0fffffc0, size 4.
//  Reset asserted mid-DATA -> outputs 0, no strobe; next cycle decodes normally.

Source files
------------

// File: rtl/lpc_decoder_multi_pkg.sv
// Shared definitions for the multi-transfer LPC decoder: FSM states, bus nibble codes,
// status codes and transfer-size decode helpers.
package lpc_decoder_multi_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CTDIR,
      ST_SIZE,
      ST_ADDR,
      ST_FW_IDSEL,
      ST_FW_ADDR,
      ST_FW_MSIZE,
      ST_TAR1,
      ST_SYNC,
      ST_DATA,
      ST_TAR2
   } state_t;

   typedef enum logic [1:0] {
      STATUS_OK       = 2'b00,
      STATUS_SYNC_ERR = 2'b01,
      STATUS_TIMEOUT  = 2'b10,
      STATUS_SIZE     = 2'b11
   } status_t;

   localparam logic [3:0] START_LPC   = 4'b0000;
   localparam logic [3:0] START_FW_RD = 4'b1101;
   localparam logic [3:0] START_FW_WR = 4'b1110;
   localparam logic [3:0] START_ABORT = 4'b1111;

   localparam logic [3:0] SYNC_READY = 4'b0000;
   localparam logic [3:0] SYNC_SHORT = 4'b0101;
   localparam logic [3:0] SYNC_LONG  = 4'b0110;
   localparam logic [3:0] SYNC_ERROR = 4'b1010;

   // LPC size nibble: byte count is code+1 so the reserved code still frames the data phase
   function automatic logic [2:0] lpc_size_bytes(input logic [1:0] code);
      case (code)
         2'd0:    lpc_size_bytes = 3'd1;
         2'd1:    lpc_size_bytes = 3'd2;
         2'd2:    lpc_size_bytes = 3'd3;
         default: lpc_size_bytes = 3'd4;
      endcase
   endfunction

   function automatic logic [2:0] fw_msize_bytes(input logic [3:0] msize);
      case (msize)
         4'b0000: fw_msize_bytes = 3'd1;
         4'b0001: fw_msize_bytes = 3'd2;
         default: fw_msize_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lpc_decoder_multi_nibble_shift.sv
// Nibble accumulator with nibble counter: MSB-first shift (address) or
// LSB-first positional load (little-endian data, right-justified).
module lpc_nibble_shift #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        shift,
   input  logic [3:0]  nibble,
   output logic [31:0] value,
   output logic [3:0]  count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
         count <= '0;
      end else if (clear) begin
         value <= '0;
         count <= '0;
      end else if (shift) begin
         if (MSB_FIRST)
            value <= {value[27:0], nibble};
         else if (!count[3])
            value[{count[2:0], 2'b00} +: 4] <= nibble;
         count <= count + 4'd1;
      end
   end

endmodule

// File: rtl/lpc_decoder_multi.sv
// Passive LPC bus decoder: follows LAD/LFRAME# through I/O, memory and FWH cycles
// and emits one registered record per completed, timed-out or failed cycle.
module lpc_decoder_multi
   import lpc_decoder_multi_pkg::*;
#(
   parameter int unsigned MAX_BYTES    = 4,
   parameter bit          ENABLE_FW    = 1'b1,
   parameter int unsigned SYNC_TIMEOUT = 64
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic [3:0]  lpc_ad,
   input  logic        lpc_frame,
   output logic [3:0]  out_cyctype_dir,
   output logic [31:0] out_addr,
   output logic [31:0] out_data,
   output logic [2:0]  out_data_size,
   output logic [1:0]  out_status,
   output logic        out_clock_enable,
   output logic        out_abort
);

   localparam int unsigned    WCW       = $clog2(SYNC_TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(SYNC_TIMEOUT - 1);

   state_t         state, state_next;
   status_t        status, status_next;
   logic           fw, fw_next;
   logic           is_mem, is_mem_next;
   logic           dir, dir_next;
   logic [2:0]     bytes, bytes_next;
   logic [WCW-1:0] wait_cnt, wait_cnt_next;
   logic           tar_odd, tar_odd_next;
   logic           acc_clear, addr_shift, data_shift;
   logic           strobe, abort;
   logic [31:0]    addr_val, data_val;
   logic [3:0]     addr_cnt, data_cnt;

   lpc_nibble_shift #(.MSB_FIRST(1'b1)) u_addr (
      .clk    (lpc_clock),
      .rst_n  (lpc_reset),
      .clear  (acc_clear),
      .shift  (addr_shift),
      .nibble (lpc_ad),
      .value  (addr_val),
      .count  (addr_cnt)
   );

   lpc_nibble_shift #(.MSB_FIRST(1'b0)) u_data (
      .clk    (lpc_clock),
      .rst_n  (lpc_reset),
      .clear  (acc_clear),
      .shift  (data_shift),
      .nibble (lpc_ad),
      .value  (data_val),
      .count  (data_cnt)
   );

   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         state    <= ST_IDLE;
         status   <= STATUS_OK;
         fw       <= 1'b0;
         is_mem   <= 1'b0;
         dir      <= 1'b0;
         bytes    <= '0;
         wait_cnt <= '0;
         tar_odd  <= 1'b0;
      end else begin
         state    <= state_next;
         status   <= status_next;
         fw       <= fw_next;
         is_mem   <= is_mem_next;
         dir      <= dir_next;
         bytes    <= bytes_next;
         wait_cnt <= wait_cnt_next;
         tar_odd  <= tar_odd_next;
      end
   end

   always_comb begin
      state_next    = state;
      status_next   = status;
      fw_next       = fw;
      is_mem_next   = is_mem;
      dir_next      = dir;
      bytes_next    = bytes;
      wait_cnt_next = wait_cnt;
      tar_odd_next  = tar_odd;
      acc_clear     = 1'b0;
      addr_shift    = 1'b0;
      data_shift    = 1'b0;
      strobe        = 1'b0;
      abort         = 1'b0;

      // LFRAME# low overrides every state: abort, or (re)start from the latest nibble
      if (!lpc_frame) begin
         if (state != ST_IDLE && lpc_ad == START_ABORT) begin
            abort      = 1'b1;
            state_next = ST_IDLE;
         end else begin
            state_next    = ST_IDLE;
            status_next   = STATUS_OK;
            fw_next       = 1'b0;
            is_mem_next   = 1'b0;
            dir_next      = 1'b0;
            wait_cnt_next = '0;
            tar_odd_next  = 1'b0;
            acc_clear     = 1'b1;
            if (lpc_ad == START_LPC) begin
               state_next = ST_CTDIR;
            end else if (ENABLE_FW && (lpc_ad == START_FW_RD || lpc_ad == START_FW_WR)) begin
               state_next = ST_FW_IDSEL;
               fw_next    = 1'b1;
               dir_next   = (lpc_ad == START_FW_WR);
            end
         end
      end else begin
         case (state)
            ST_CTDIR: begin
               if (lpc_ad[3]) begin
                  state_next = ST_IDLE;
               end else begin
                  is_mem_next = lpc_ad[2];
                  dir_next    = lpc_ad[1];
                  state_next  = ST_SIZE;
               end
            end
            ST_SIZE: begin
               bytes_next = lpc_size_bytes(lpc_ad[1:0]);
               if (lpc_ad[3:2] != 2'b00 || lpc_ad[1:0] == 2'd2 ||
                   32'(lpc_size_bytes(lpc_ad[1:0])) > MAX_BYTES)
                  status_next = STATUS_SIZE;
               state_next = ST_ADDR;
            end
            ST_ADDR: begin
               addr_shift = 1'b1;
               if (addr_cnt == (is_mem ? 4'd7 : 4'd3))
                  state_next = dir ? ST_DATA : ST_TAR1;
            end
            ST_FW_IDSEL: begin
               addr_shift = 1'b1;
               state_next = ST_FW_ADDR;
            end
            ST_FW_ADDR: begin
               addr_shift = 1'b1;
               if (addr_cnt == 4'd7)
                  state_next = ST_FW_MSIZE;
            end
            ST_FW_MSIZE: begin
               bytes_next = fw_msize_bytes(lpc_ad);
               if (lpc_ad > 4'b0010 || 32'(fw_msize_bytes(lpc_ad)) > MAX_BYTES)
                  status_next = STATUS_SIZE;
               state_next = dir ? ST_DATA : ST_TAR1;
            end
            ST_TAR1: begin
               tar_odd_next = !tar_odd;
               if (tar_odd)
                  state_next = ST_SYNC;
            end
            ST_SYNC: begin
               case (lpc_ad)
                  SYNC_READY: state_next = dir ? ST_TAR2 : ST_DATA;
                  SYNC_SHORT, SYNC_LONG: begin
                     if (wait_cnt == WAIT_LAST) begin
                        strobe      = 1'b1;
                        status_next = STATUS_TIMEOUT;
                        state_next  = ST_IDLE;
                     end else begin
                        wait_cnt_next = wait_cnt + WCW'(1);
                     end
                  end
                  SYNC_ERROR: begin
                     if (status == STATUS_OK)
                        status_next = STATUS_SYNC_ERR;
                     state_next = dir ? ST_TAR2 : ST_DATA;
                  end
                  default: begin
                     if (status == STATUS_OK)
                        status_next = STATUS_SYNC_ERR;
                     state_next = ST_TAR2;
                  end
               endcase
            end
            ST_DATA: begin
               data_shift = 1'b1;
               if (data_cnt == ({bytes, 1'b0} - 4'd1))
                  state_next = dir ? ST_TAR1 : ST_TAR2;
            end
            ST_TAR2: begin
               tar_odd_next = !tar_odd;
               if (tar_odd) begin
                  strobe     = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         out_cyctype_dir  <= '0;
         out_addr         <= '0;
         out_data         <= '0;
         out_data_size    <= '0;
         out_status       <= '0;
         out_clock_enable <= 1'b0;
         out_abort        <= 1'b0;
      end else begin
         out_clock_enable <= strobe;
         out_abort        <= abort;
         if (strobe) begin
            out_cyctype_dir <= fw ? {2'b11, dir, 1'b0} : {1'b0, is_mem, dir, 1'b0};
            out_addr        <= addr_val;
            out_data        <= (status_next == STATUS_SIZE || status_next == STATUS_TIMEOUT)
                               ? '0 : data_val;
            out_data_size   <= bytes;
            out_status      <= status_next;
         end
      end
   end

endmodule

// File: tb/tb_lpc_decoder_multi.sv
// Directed self-checking bench for lpc_decoder_multi: drives LAD/LFRAME# nibble by nibble
// and compares captured records against hand-computed values.
module tb_lpc_decoder_multi;

   logic        lpc_clock;
   logic        lpc_reset;
   logic [3:0]  lpc_ad;
   logic        lpc_frame;
   logic [3:0]  out_cyctype_dir;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [2:0]  out_data_size;
   logic [1:0]  out_status;
   logic        out_clock_enable;
   logic        out_abort;

   typedef struct packed {
      logic [3:0]  ct;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  size;
      logic [1:0]  status;
   } rec_t;

   rec_t        recs[$];
   int unsigned abort_cnt;
   int unsigned tests;
   int unsigned fails;

   lpc_decoder_multi #(
      .MAX_BYTES    (4),
      .ENABLE_FW    (1'b1),
      .SYNC_TIMEOUT (8)
   ) dut (
      .lpc_clock        (lpc_clock),
      .lpc_reset        (lpc_reset),
      .lpc_ad           (lpc_ad),
      .lpc_frame        (lpc_frame),
      .out_cyctype_dir  (out_cyctype_dir),
      .out_addr         (out_addr),
      .out_data         (out_data),
      .out_data_size    (out_data_size),
      .out_status       (out_status),
      .out_clock_enable (out_clock_enable),
      .out_abort        (out_abort)
   );

   initial lpc_clock = 1'b0;
   always #5 lpc_clock = ~lpc_clock;

   always @(negedge lpc_clock) begin
      if (out_clock_enable)
         recs.push_back('{ct: out_cyctype_dir, addr: out_addr, data: out_data,
                          size: out_data_size, status: out_status});
      if (out_abort)
         abort_cnt++;
   end

   task automatic send(input logic f, input logic [3:0] a);
      @(negedge lpc_clock);
      lpc_frame = f;
      lpc_ad    = a;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) send(1'b1, 4'hf);
   endtask

   task automatic send_addr(input logic [31:0] a, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) send(1'b1, a[(n - 1 - i) * 4 +: 4]);
   endtask

   task automatic send_data(input logic [31:0] d, input int unsigned nbytes);
      for (int unsigned i = 0; i < 2 * nbytes; i++) send(1'b1, d[i * 4 +: 4]);
   endtask

   task automatic tar();
      send(1'b1, 4'hf);
      send(1'b1, 4'hf);
   endtask

   task automatic test_reset();
      rec_t r;
      lpc_reset = 1'b0;
      lpc_frame = 1'b1;
      lpc_ad    = 4'hf;
      #12;
      r = '{ct: out_cyctype_dir, addr: out_addr, data: out_data, size: out_data_size, status: out_status};
      tests++;
      if (r !== '0 || out_clock_enable !== 1'b0 || out_abort !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs got rec=%h ce=%b ab=%b exp all 0", r, out_clock_enable, out_abort);
      end
      @(negedge lpc_clock);
      lpc_reset = 1'b1;
      idle(2);
      tests++;
      if (recs.size() !== 0) begin
         fails++;
         $display("FAIL reset_no_strobe got %0d records exp 0", recs.size());
      end
   endtask

   task automatic test_mem_read_2b();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h4); send(1'b1, 4'h1);
      send_addr(32'haffe7fe5, 8); tar();
      send(1'b1, 4'h0); send_data(32'h0000df6c, 2); tar();
      idle(3);
      e = '{ct: 4'h4, addr: 32'haffe7fe5, data: 32'h0000df6c, size: 3'd2, status: 2'b00};
      tests++;
      if (recs.size() !== 1) begin
         fails++;
         $display("FAIL mem_rd2_count got %0d exp 1", recs.size());
      end
      r = (recs.size() != 0) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL mem_rd2_rec got %h exp %h", r, e);
      end
   endtask

   task automatic test_io_write_1b();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h2); send(1'b1, 4'h0);
      send_addr(32'h0080, 4); send_data(32'h5a, 1); tar();
      send(1'b1, 4'h0); tar();
      idle(3);
      e = '{ct: 4'h2, addr: 32'h00000080, data: 32'h0000005a, size: 3'd1, status: 2'b00};
      tests++;
      if (recs.size() !== 1) begin
         fails++;
         $display("FAIL io_wr1_count got %0d exp 1", recs.size());
      end
      r = (recs.size() != 0) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL io_wr1_rec got %h exp %h", r, e);
      end
   endtask

   task automatic test_mem_read_4b_wait();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h4); send(1'b1, 4'h3);
      send_addr(32'h000f0000, 8); tar();
      for (int unsigned i = 0; i < 3; i++) send(1'b1, 4'h6);
      send(1'b1, 4'h0); send_data(32'h12345678, 4); tar();
      idle(3);
      e = '{ct: 4'h4, addr: 32'h000f0000, data: 32'h12345678, size: 3'd4, status: 2'b00};
      r = (recs.size() == 1) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL mem_rd4_wait_rec got %h exp %h", r, e);
      end
   endtask

   task automatic test_wait_boundary();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h0); send(1'b1, 4'h0);
      send_addr(32'h0060, 4); tar();
      for (int unsigned i = 0; i < 7; i++) send(1'b1, 4'h5);
      send(1'b1, 4'h0); send_data(32'h81, 1); tar();
      idle(3);
      e = '{ct: 4'h0, addr: 32'h00000060, data: 32'h00000081, size: 3'd1, status: 2'b00};
      r = (recs.size() == 1) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL wait7_rec got %h exp %h", r, e);
      end
   endtask

   task automatic test_timeout();
      rec_t r;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h4); send(1'b1, 4'h3);
      send_addr(32'h11223344, 8); tar();
      for (int unsigned i = 0; i < 9; i++) send(1'b1, 4'h5);
      idle(4);
      tests++;
      if (recs.size() !== 1) begin
         fails++;
         $display("FAIL timeout_count got %0d exp 1", recs.size());
      end
      r = (recs.size() != 0) ? recs.pop_front() : '0;
      tests++;
      if (r.status !== 2'b10 || r.data !== 32'h0) begin
         fails++;
         $display("FAIL timeout_rec got status=%b data=%h exp status=10 data=0", r.status, r.data);
      end
   endtask

   task automatic test_abort();
      int unsigned a0;
      recs.delete();
      a0 = abort_cnt;
      send(1'b0, 4'h0); send(1'b1, 4'h4); send(1'b1, 4'h0);
      send(1'b1, 4'ha); send(1'b1, 4'hb); send(1'b1, 4'hc);
      send(1'b0, 4'hf);
      idle(4);
      tests++;
      if (abort_cnt - a0 !== 1) begin
         fails++;
         $display("FAIL abort_pulse got %0d pulse cycles exp 1", abort_cnt - a0);
      end
      tests++;
      if (recs.size() !== 0) begin
         fails++;
         $display("FAIL abort_no_strobe got %0d records exp 0", recs.size());
      end
   endtask

   task automatic test_abort_recovery();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h0); send(1'b1, 4'h0);
      send_addr(32'h03f8, 4); tar();
      send(1'b1, 4'h0); send_data(32'ha5, 1); tar();
      idle(3);
      e = '{ct: 4'h0, addr: 32'h000003f8, data: 32'h000000a5, size: 3'd1, status: 2'b00};
      r = (recs.size() == 1) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL abort_recovery_rec got %h exp %h", r, e);
      end
   endtask

   task automatic test_fwh_read();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'hd); send(1'b1, 4'h0);
      send_addr(32'h0fffffc0, 7); send(1'b1, 4'h2); tar();
      send(1'b1, 4'h0); send_data(32'hcafebabe, 4); tar();
      idle(3);
      e = '{ct: 4'hc, addr: 32'h0fffffc0, data: 32'hcafebabe, size: 3'd4, status: 2'b00};
      r = (recs.size() == 1) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL fwh_read_rec got %h exp %h", r, e);
      end
   endtask

   task automatic test_sync_error();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h0); send(1'b1, 4'h0);
      send_addr(32'h0064, 4); tar();
      send(1'b1, 4'ha); send_data(32'h3c, 1); tar();
      idle(3);
      e = '{ct: 4'h0, addr: 32'h00000064, data: 32'h0000003c, size: 3'd1, status: 2'b01};
      r = (recs.size() == 1) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL sync_error_rec got %h exp %h", r, e);
      end
   endtask

   task automatic test_back_to_back();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h0); send(1'b1, 4'h0);
      send_addr(32'h0070, 4); tar();
      send(1'b1, 4'h0); send_data(32'h11, 1); tar();
      send(1'b0, 4'h0); send(1'b1, 4'h2); send(1'b1, 4'h0);
      send_addr(32'h0071, 4); send_data(32'h22, 1); tar();
      send(1'b1, 4'h0); tar();
      idle(3);
      tests++;
      if (recs.size() !== 2) begin
         fails++;
         $display("FAIL b2b_count got %0d exp 2", recs.size());
      end
      e = '{ct: 4'h0, addr: 32'h00000070, data: 32'h00000011, size: 3'd1, status: 2'b00};
      r = (recs.size() != 0) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL b2b_first got %h exp %h", r, e);
      end
      e = '{ct: 4'h2, addr: 32'h00000071, data: 32'h00000022, size: 3'd1, status: 2'b00};
      r = (recs.size() != 0) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL b2b_second got %h exp %h", r, e);
      end
   endtask

   task automatic test_reset_mid_data();
      rec_t r;
      rec_t e;
      recs.delete();
      send(1'b0, 4'h0); send(1'b1, 4'h4); send(1'b1, 4'h1);
      send_addr(32'h00001234, 8); tar();
      send(1'b1, 4'h0); send(1'b1, 4'hc); send(1'b1, 4'h6);
      @(negedge lpc_clock);
      lpc_reset = 1'b0;
      #2;
      r = '{ct: out_cyctype_dir, addr: out_addr, data: out_data, size: out_data_size, status: out_status};
      tests++;
      if (r !== '0) begin
         fails++;
         $display("FAIL midreset_outputs got %h exp 0", r);
      end
      idle(2);
      lpc_reset = 1'b1;
      send(1'b1, 4'hf); send(1'b1, 4'hf); idle(3);
      tests++;
      if (recs.size() !== 0) begin
         fails++;
         $display("FAIL midreset_no_strobe got %0d records exp 0", recs.size());
      end
      send(1'b0, 4'h0); send(1'b1, 4'h2); send(1'b1, 4'h0);
      send_addr(32'h0080, 4); send_data(32'h5a, 1); tar();
      send(1'b1, 4'h0); tar();
      idle(3);
      e = '{ct: 4'h2, addr: 32'h00000080, data: 32'h0000005a, size: 3'd1, status: 2'b00};
      r = (recs.size() == 1) ? recs.pop_front() : '0;
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL midreset_next_rec got %h exp %h", r, e);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      abort_cnt = 0;
      test_reset();
      test_mem_read_2b();
      test_io_write_1b();
      test_mem_read_4b_wait();
      test_wait_boundary();
      test_timeout();
      test_abort();
      test_abort_recovery();
      test_fwh_read();
      test_sync_error();
      test_back_to_back();
      test_reset_mid_data();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
